ram_sdp_pipe: RTL and testbench
===============================

Name: ram_sdp_pipe

Overview:
Parametrised simple-dual-port RAM: one write port and one independent read port on a single clock.
- Per-byte write enables, configurable read latency and selectable read-during-write behaviour.
- Out-of-range address detection on both ports.
- Successor to the single-port test RAM; used as a generic buffer behind FIFOs and line caches in the datapath.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane
ADDR_WIDTH, 12, address width
RAM_SIZE, 3072, number of words; must be <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from RDEN to RD_VALID; legal range 1..4
RDW_NEW, 0, read-during-write to the same address: 0 returns old data, 1 returns newly written bytes

Ports:
CLK  in  1  clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
WREN  in  1  write request
WR_ADDR  in  ADDR_WIDTH  write address
WR_BE  in  DATA_WIDTH/BYTE_WIDTH  byte-lane enables
WR_DATA  in  DATA_WIDTH  write data
RDEN  in  1  read request
RD_ADDR  in  ADDR_WIDTH  read address
RD_DATA  out  DATA_WIDTH  read data, held until next valid read
RD_VALID  out  1  one-cycle pulse marking RD_DATA valid
RD_OOR  out  1  aligned with RD_VALID: read address was >= RAM_SIZE
WR_OOR  out  1  registered one-cycle pulse: write address was >= RAM_SIZE
RD_PERR  out  1  parity error flag, aligned with RD_VALID (see Optional Feature)

Behaviour:
Reset:
- Async assertion clears RD_DATA=0, RD_VALID=0, RD_OOR=0, WR_OOR=0, RD_PERR=0 and all read-pipeline valid bits.
- Memory contents are not reset.
- Deassertion is synchronised by the integrator; the first edge after release is a normal cycle.
- A read in flight when reset asserts is discarded; no RD_VALID is ever emitted for it.

Write:
- On an edge with WREN=1 and WR_ADDR<RAM_SIZE, bytes with WR_BE[i]=1 are updated; other bytes are unchanged.
- WR_BE all zero: no write and no error.
- WR_ADDR>=RAM_SIZE: memory is untouched and WR_OOR pulses on the next cycle.

Read:
- An edge with RDEN=1 launches a read. RD_VALID pulses exactly READ_LATENCY cycles later.
- Back-to-back reads every cycle are fully pipelined, one result per cycle, in order.
- Address >= RAM_SIZE: RD_DATA=0, RD_OOR=1 with that RD_VALID.
- RD_DATA only changes on cycles with RD_VALID=1.

Read-during-write:
- Applies when WREN and RDEN are both 1 on the same edge with equal in-range addresses.
- RDW_NEW=0: result is the pre-write word.
- RDW_NEW=1: enabled bytes come from WR_DATA, disabled bytes from memory.
- Different addresses: no interaction.
- A write to an address already read earlier in the pipeline does not alter that read's result.

Width rules:
- Address comparison is unsigned and full ADDR_WIDTH.
- Byte count is DATA_WIDTH/BYTE_WIDTH; a non-integer ratio is an elaboration error, and so are READ_LATENCY outside 1..4 and RAM_SIZE>2**ADDR_WIDTH.

Optional Feature:
Macro: RAM_SDP_PARITY_EN.

Defined:
- Each byte lane stores one extra even-parity bit, computed from WR_DATA at write time.
- On read, parity is rechecked at the memory output.
- RD_PERR=1 with RD_VALID if any lane mismatches; RD_DATA is returned unmodified.
- For RDW_NEW bypassed bytes, parity is computed from WR_DATA, so no error is possible on those lanes.
- OOR reads report RD_PERR=0.

Not defined:
- No parity storage; RD_PERR is tied to 0.
- Port list is identical in both builds.

Test Plan:
1. Reset then write 0xBEEF at address 5 with BE=2'b11, read address 5 (READ_LATENCY=1) -> RD_VALID one cycle later, RD_DATA=0xBEEF, RD_OOR=0.
2. Write 0x1234 at 7, then write 0xAB00 at 7 with BE=2'b10, read 7 -> RD_DATA=0xAB34.
3. READ_LATENCY=3: reads of addresses 1,2,3 on consecutive cycles holding 0x0011,0x0022,0x0033 -> RD_VALID high on cycles 3,4,5, data in order.
4. Same-edge write 0x5555 and read of address 9 (old 0xAAAA): RDW_NEW=0 -> 0xAAAA; RDW_NEW=1 -> 0x5555; a following read returns 0x5555 in both.
5. Write to address 3072 -> WR_OOR pulse, no memory change. Read address 4095 -> RD_DATA=0, RD_OOR=1.
6. Launch read with READ_LATENCY=4, assert RST_N=0 asynchronously two cycles later -> outputs clear immediately, no RD_VALID after release. With RAM_SDP_PARITY_EN, force a flipped stored bit -> RD_PERR=1 on that read.

Source files
------------

// File: rtl/ram_sdp_pipe.sv
// Simple-dual-port RAM: one write port, one independent read port, single clock.
// Per-byte write enables, READ_LATENCY-deep read pipeline (1..4), selectable
// read-during-write result, out-of-range flags on both ports.
// Optional build macro RAM_SDP_PARITY_EN adds one even-parity bit per byte
// lane, checked on read and reported on RD_PERR; otherwise RD_PERR is 0.
module ram_sdp_pipe #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned RAM_SIZE     = 3072,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RDW_NEW      = 0
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             WREN,
    input  logic [ADDR_WIDTH-1:0]            WR_ADDR,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WR_BE,
    input  logic [DATA_WIDTH-1:0]            WR_DATA,
    input  logic                             RDEN,
    input  logic [ADDR_WIDTH-1:0]            RD_ADDR,
    output logic [DATA_WIDTH-1:0]            RD_DATA,
    output logic                             RD_VALID,
    output logic                             RD_OOR,
    output logic                             WR_OOR,
    output logic                             RD_PERR
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(RAM_SIZE);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_byte
        $error("ram_sdp_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_err_lat
        $error("ram_sdp_pipe: READ_LATENCY must be in 1..4");
    end
    if (64'(RAM_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_err_size
        $error("ram_sdp_pipe: RAM_SIZE exceeds 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];
`ifdef RAM_SDP_PARITY_EN
    logic [NUM_BYTES-1:0]  mem_par [RAM_SIZE];
    logic [NUM_BYTES-1:0]  rd_par;
`endif

    logic                  wr_in;
    logic                  rd_in;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s0_perr;
    logic                  tail_vld;
    logic                  tail_oor;
    logic                  tail_perr;
    logic [DATA_WIDTH-1:0] tail_data;

    assign wr_in     = {1'b0, WR_ADDR} < ADDR_LIMIT;
    assign rd_in     = {1'b0, RD_ADDR} < ADDR_LIMIT;
    assign same_addr = WREN && RDEN && rd_in && (WR_ADDR == RD_ADDR);

    // Byte-lane write into the array; out-of-range addresses never touch it
    always_ff @(posedge CLK) begin
        if (WREN && wr_in) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (WR_BE[i]) begin
                    mem[WR_ADDR][i*BYTE_WIDTH +: BYTE_WIDTH] <= WR_DATA[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM_SDP_PARITY_EN
                    mem_par[WR_ADDR][i] <= ^WR_DATA[i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
                end
            end
        end
    end

    // Launch stage: pre-write array word, optional same-address bypass, parity check
    always_comb begin
        rd_word = '0;
        s0_data = '0;
        s0_perr = 1'b0;
`ifdef RAM_SDP_PARITY_EN
        rd_par  = '0;
`endif
        if (rd_in) begin
            rd_word = mem[RD_ADDR];
`ifdef RAM_SDP_PARITY_EN
            rd_par  = mem_par[RD_ADDR];
`endif
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (RDW_NEW != 0 && same_addr && WR_BE[i]) begin
                    s0_data[i*BYTE_WIDTH +: BYTE_WIDTH] = WR_DATA[i*BYTE_WIDTH +: BYTE_WIDTH];
                end else begin
                    s0_data[i*BYTE_WIDTH +: BYTE_WIDTH] = rd_word[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef RAM_SDP_PARITY_EN
                    if (^{rd_word[i*BYTE_WIDTH +: BYTE_WIDTH], rd_par[i]}) begin
                        s0_perr = 1'b1;
                    end
`endif
                end
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign tail_vld  = RDEN;
        assign tail_oor  = !rd_in;
        assign tail_perr = s0_perr;
        assign tail_data = s0_data;
    end else begin : g_pipe
        localparam int unsigned DEPTH = READ_LATENCY - 1;
        logic [DEPTH-1:0]      p_vld;
        logic [DEPTH-1:0]      p_oor;
        logic [DEPTH-1:0]      p_perr;
        logic [DATA_WIDTH-1:0] p_data [DEPTH];

        // Extra latency stages; the result is captured at launch so later writes cannot alter it
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                p_vld  <= '0;
                p_oor  <= '0;
                p_perr <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) p_data[i] <= '0;
            end else begin
                p_vld[0]  <= RDEN;
                p_oor[0]  <= !rd_in;
                p_perr[0] <= s0_perr;
                p_data[0] <= s0_data;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    p_vld[i]  <= p_vld[i-1];
                    p_oor[i]  <= p_oor[i-1];
                    p_perr[i] <= p_perr[i-1];
                    p_data[i] <= p_data[i-1];
                end
            end
        end

        assign tail_vld  = p_vld[DEPTH-1];
        assign tail_oor  = p_oor[DEPTH-1];
        assign tail_perr = p_perr[DEPTH-1];
        assign tail_data = p_data[DEPTH-1];
    end

    // Output registers: data held between valid reads, flags pulse with RD_VALID
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
            RD_OOR   <= 1'b0;
            RD_PERR  <= 1'b0;
            WR_OOR   <= 1'b0;
        end else begin
            RD_VALID <= tail_vld;
            RD_OOR   <= tail_vld && tail_oor;
            RD_PERR  <= tail_vld && !tail_oor && tail_perr;
            WR_OOR   <= WREN && !wr_in;
            if (tail_vld) begin
                RD_DATA <= tail_oor ? '0 : tail_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp_pipe.sv
// Self-checking bench for ram_sdp_pipe: three instances with different
// READ_LATENCY / RDW_NEW settings share one stimulus stream; a word-level
// reference memory plus an expected-result queue predicts every output.
module tb_ram_sdp_pipe;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned RS = 3072;
    localparam int unsigned NB = 2;
    localparam int unsigned ND = 3;
    localparam int unsigned LAT [ND] = '{1, 3, 4};
    localparam int unsigned RDW [ND] = '{0, 1, 0};

    logic          CLK     = 1'b0;
    logic          RST_N   = 1'b0;
    logic          wren    = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [NB-1:0] wr_be   = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rden    = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [ND-1:0][DW-1:0] rd_data;
    logic [ND-1:0]         rd_valid;
    logic [ND-1:0]         rd_oor;
    logic [ND-1:0]         wr_oor;
    logic [ND-1:0]         rd_perr;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ram_sdp_pipe #(
            .DATA_WIDTH  (DW),
            .BYTE_WIDTH  (8),
            .ADDR_WIDTH  (AW),
            .RAM_SIZE    (RS),
            .READ_LATENCY(LAT[g]),
            .RDW_NEW     (RDW[g])
        ) u_ram (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .WREN    (wren),
            .WR_ADDR (wr_addr),
            .WR_BE   (wr_be),
            .WR_DATA (wr_data),
            .RDEN    (rden),
            .RD_ADDR (rd_addr),
            .RD_DATA (rd_data[g]),
            .RD_VALID(rd_valid[g]),
            .RD_OOR  (rd_oor[g]),
            .WR_OOR  (wr_oor[g]),
            .RD_PERR (rd_perr[g])
        );
    end

    typedef struct {
        int unsigned   dut;
        int unsigned   due;
        logic [DW-1:0] data;
        logic          oor;
        logic          perr;
    } rd_exp_t;

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    int unsigned   edge_cnt    = 0;
    rd_exp_t       exp_q [$];
    logic [DW-1:0] ref_mem [RS];
    logic [DW-1:0] held [ND];
    logic          exp_wr_oor  = 1'b0;
    logic [ND-1:0] perr_inj    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic check_outputs();
        int      idx;
        logic    exp_v;
        rd_exp_t e;
        for (int unsigned d = 0; d < ND; d++) begin
            idx   = -1;
            exp_v = 1'b0;
            e     = '{default: '0};
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].dut == d) begin
                    idx = i;
                    break;
                end
            end
            if (idx >= 0 && exp_q[idx].due == edge_cnt) begin
                e = exp_q[idx];
                exp_q.delete(idx);
                exp_v   = 1'b1;
                held[d] = e.data;
            end
            check($sformatf("rd_valid[%0d]", d), 32'(rd_valid[d]), 32'(exp_v));
            check($sformatf("rd_data[%0d]", d), 32'(rd_data[d]), 32'(held[d]));
            check($sformatf("rd_oor[%0d]", d), 32'(rd_oor[d]), 32'(exp_v & e.oor));
            check($sformatf("rd_perr[%0d]", d), 32'(rd_perr[d]), 32'(exp_v & e.perr));
            check($sformatf("wr_oor[%0d]", d), 32'(wr_oor[d]), 32'(exp_wr_oor));
        end
    endtask

    // One clock: drive at negedge, predict, then check #1 after the rising edge.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        rd_exp_t e;
        @(negedge CLK);
        wren = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rden = re; rd_addr = ra;
        if (re && RST_N) begin
            for (int unsigned d = 0; d < ND; d++) begin
                e.dut = d;
                e.due = edge_cnt + LAT[d];
                if (32'(ra) >= RS) begin
                    e.data = '0; e.oor = 1'b1; e.perr = 1'b0;
                end else begin
                    e.data = ref_mem[ra];
                    if (RDW[d] != 0 && we && wa == ra) begin
                        for (int b = 0; b < NB; b++)
                            if (be[b]) e.data[b*8 +: 8] = wd[b*8 +: 8];
                    end
                    e.oor  = 1'b0;
                    e.perr = perr_inj[d];
                end
                exp_q.push_back(e);
            end
        end
        if (we && RST_N && 32'(wa) < RS) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) ref_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
        end
        @(posedge CLK);
        edge_cnt++;
        exp_wr_oor = we && RST_N && (32'(wa) >= RS);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)  return AW'($urandom_range(0, 15));
        if (r == 7) return AW'(3070 + $urandom_range(0, 1));
        if (r == 8) return AW'(3072 + $urandom_range(0, 1));
        return AW'(4095);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          we, re;
        logic [AW-1:0] wa, ra;
        logic [NB-1:0] be;
        logic [DW-1:0] wd;

        for (int unsigned d = 0; d < ND; d++) held[d] = '0;

        // Reset state
        idle(3);
        @(negedge CLK);
        RST_N = 1'b1;

        // Fill the working window so every later read has a defined expectation
        for (int unsigned a = 0; a < 16; a++) cycle(1'b1, AW'(a), 2'b11, DW'($urandom), 1'b0, '0);
        cycle(1'b1, AW'(3070), 2'b11, DW'($urandom), 1'b0, '0);
        cycle(1'b1, AW'(3071), 2'b11, DW'($urandom), 1'b0, '0);

        // Full-word write then latency-1 read
        cycle(1'b1, AW'(5), 2'b11, 16'hBEEF, 1'b0, '0);
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(5));
        check("t1_valid", 32'(rd_valid[0]), 32'd1);
        check("t1_data", 32'(rd_data[0]), 32'hBEEF);

        // Upper-lane-only write merges with existing low byte
        cycle(1'b1, AW'(7), 2'b11, 16'h1234, 1'b0, '0);
        cycle(1'b1, AW'(7), 2'b10, 16'hAB00, 1'b0, '0);
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(7));
        check("t2_data", 32'(rd_data[0]), 32'hAB34);

        // Back-to-back reads through the 3-deep instance
        cycle(1'b1, AW'(1), 2'b11, 16'h0011, 1'b0, '0);
        cycle(1'b1, AW'(2), 2'b11, 16'h0022, 1'b0, '0);
        cycle(1'b1, AW'(3), 2'b11, 16'h0033, 1'b0, '0);
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(1));
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(2));
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(3));
        check("t3_first", 32'(rd_data[1]), 32'h0011);
        idle(1);
        check("t3_second", 32'(rd_data[1]), 32'h0022);
        idle(1);
        check("t3_third", 32'(rd_data[1]), 32'h0033);
        idle(2);

        // Read-during-write to the same address
        cycle(1'b1, AW'(9), 2'b11, 16'hAAAA, 1'b0, '0);
        cycle(1'b1, AW'(9), 2'b11, 16'h5555, 1'b1, AW'(9));
        check("t4_old_rdw0", 32'(rd_data[0]), 32'hAAAA);
        idle(2);
        check("t4_new_rdw1", 32'(rd_data[1]), 32'h5555);
        idle(1);
        check("t4_old_lat4", 32'(rd_data[2]), 32'hAAAA);
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(9));
        check("t4_after", 32'(rd_data[0]), 32'h5555);
        idle(3);

        // Out-of-range write and read
        cycle(1'b1, AW'(3072), 2'b11, 16'hFFFF, 1'b0, '0);
        check("t5_wr_oor", 32'(wr_oor[0]), 32'd1);
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(4095));
        check("t5_rd_oor", 32'(rd_oor[0]), 32'd1);
        check("t5_rd_zero", 32'(rd_data[0]), 32'd0);
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(3071));
        check("t5_last_word", 32'(rd_data[0]), 32'(ref_mem[3071]));
        idle(4);

        // Randomized traffic over a small window, boundary words and OOR addresses
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = pick_addr();
            be = NB'($urandom);
            wd = DW'($urandom);
            if (32'(wa) >= RS && be == '0) be = 2'b01;
            re = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
            cycle(we, wa, be, wd, re, ra);
        end
        idle(6);

`ifdef RAM_SDP_PARITY_EN
        // Corrupt a stored parity bit in every instance; the next read of that word must flag it
        g_dut[0].u_ram.mem_par[12][0] = ~g_dut[0].u_ram.mem_par[12][0];
        g_dut[1].u_ram.mem_par[12][0] = ~g_dut[1].u_ram.mem_par[12][0];
        g_dut[2].u_ram.mem_par[12][0] = ~g_dut[2].u_ram.mem_par[12][0];
        perr_inj = '1;
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(12));
        perr_inj = '0;
        check("perr_flag", 32'(rd_perr[0]), 32'd1);
        idle(4);
`endif

        // Async reset with a read still in flight in the deeper pipelines
        cycle(1'b0, '0, '0, '0, 1'b1, AW'(5));
        idle(1);
        #2;
        RST_N = 1'b0;
        #1;
        for (int unsigned d = 0; d < ND; d++) begin
            check($sformatf("rst_valid[%0d]", d), 32'(rd_valid[d]), 32'd0);
            check($sformatf("rst_data[%0d]", d), 32'(rd_data[d]), 32'd0);
            check($sformatf("rst_oor[%0d]", d), 32'(rd_oor[d]), 32'd0);
            check($sformatf("rst_wr_oor[%0d]", d), 32'(wr_oor[d]), 32'd0);
            check($sformatf("rst_perr[%0d]", d), 32'(rd_perr[d]), 32'd0);
            held[d] = '0;
        end
        exp_q.delete();
        exp_wr_oor = 1'b0;
        idle(2);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
